// File: rtl/decode.sv
// Instruction decode stage: operand read/bypass, immediates, ID-resolved control transfer,
// hazard detection and ID/EX registers. Optional DECODE_ILLEGAL_TRAP_EN adds illegal_ex.
module decode #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      pc_decode,
  input  logic [31:0]          instr_decode,
  output logic [RF_ADDR_W-1:0] rs1_addr,
  output logic [RF_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]      rs1_rdata,
  input  logic [XLEN-1:0]      rs2_rdata,
  input  logic                 wb_we,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 mem_reg_we,
  input  logic [RF_ADDR_W-1:0] mem_rd,
  output logic [1:0]           pc_sel,
  output logic [XLEN-1:0]      br_decode,
  output logic [XLEN-1:0]      jal_decode,
  output logic [XLEN-1:0]      jalr_decode,
  output logic                 stall_if,
  output logic                 flush_if,
  output logic [XLEN-1:0]      pc_ex,
  output logic [XLEN-1:0]      rs1_data_ex,
  output logic [XLEN-1:0]      rs2_data_ex,
  output logic [XLEN-1:0]      imm_ex,
  output logic [RF_ADDR_W-1:0] rd_ex,
  output logic [2:0]           funct3_ex,
  output logic                 funct7b5_ex,
  output logic [6:0]           opcode_ex,
  output logic                 reg_we_ex,
  output logic                 mem_re_ex,
  output logic                 mem_we_ex,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                 illegal_ex,
`endif
  output logic                 valid_ex
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      imm;
    logic [RF_ADDR_W-1:0] rd;
    logic [2:0]           f3;
    logic                 f7b5;
    logic [6:0]           opc;
    logic                 reg_we;
    logic                 mem_re;
    logic                 mem_we;
    logic                 vld;
  } idex_t;

  idex_t r_idex, w_nxt;

  logic [6:0]           w_opc;
  logic [2:0]           w_f3;
  logic [RF_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]      w_op1, w_op2;
  logic [XLEN-1:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_load, w_store, w_opimm, w_op;
  logic w_br_ok, w_legal, w_illegal, w_use1, w_use2, w_has_rd, w_taken;
  logic w_hz_lu, w_hz_ctl, w_hz;

  assign w_opc = instr_decode[6:0];
  assign w_f3  = instr_decode[14:12];
  assign w_rs1 = RF_ADDR_W'(instr_decode[19:15]);
  assign w_rs2 = RF_ADDR_W'(instr_decode[24:20]);
  assign w_rd  = RF_ADDR_W'(instr_decode[11:7]);
  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  assign w_imm_i = XLEN'($signed(instr_decode[31:20]));
  assign w_imm_s = XLEN'($signed({instr_decode[31:25], instr_decode[11:7]}));
  assign w_imm_b = XLEN'($signed({instr_decode[31], instr_decode[7], instr_decode[30:25],
                                  instr_decode[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({instr_decode[31:12], 12'h000}));
  assign w_imm_j = XLEN'($signed({instr_decode[31], instr_decode[19:12], instr_decode[20],
                                  instr_decode[30:21], 1'b0}));

  // Writeback bypass; x0 never forwards and always reads zero.
  always_comb begin
    w_op1 = rs1_rdata;
    w_op2 = rs2_rdata;
    if (wb_we && wb_rd == w_rs1) w_op1 = wb_data;
    if (wb_we && wb_rd == w_rs2) w_op2 = wb_data;
    if (w_rs1 == '0) w_op1 = '0;
    if (w_rs2 == '0) w_op2 = '0;
  end

  always_comb begin
    w_lui   = (w_opc == OP_LUI);
    w_auipc = (w_opc == OP_AUIPC);
    w_jal   = (w_opc == OP_JAL);
    w_jalr  = (w_opc == OP_JALR);
    w_br    = (w_opc == OP_BR);
    w_load  = (w_opc == OP_LOAD);
    w_store = (w_opc == OP_STORE);
    w_opimm = (w_opc == OP_IMM);
    w_op    = (w_opc == OP_OP);
    w_br_ok = w_br && (w_f3 != 3'b010) && (w_f3 != 3'b011);
    w_legal = (instr_decode != 32'h0) &&
              (w_lui | w_auipc | w_jal | w_jalr | w_br_ok | w_load | w_store | w_opimm | w_op);
    w_illegal = (instr_decode != 32'h0) && !w_legal;
    w_use1  = w_legal && !(w_lui | w_auipc | w_jal);
    w_use2  = w_legal && (w_br_ok | w_store | w_op);
    w_has_rd = w_legal && !(w_br_ok | w_store);
  end

  always_comb begin
    w_imm = '0;
    if (w_lui | w_auipc)        w_imm = w_imm_u;
    else if (w_jal | w_jalr)    w_imm = XLEN'(4);
    else if (w_load | w_opimm)  w_imm = w_imm_i;
    else if (w_store)           w_imm = w_imm_s;
    else if (w_br)              w_imm = w_imm_b;
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (w_op1 == w_op2);
      3'b001:  w_taken = (w_op1 != w_op2);
      3'b100:  w_taken = ($signed(w_op1) <  $signed(w_op2));
      3'b101:  w_taken = ($signed(w_op1) >= $signed(w_op2));
      3'b110:  w_taken = (w_op1 <  w_op2);
      3'b111:  w_taken = (w_op1 >= w_op2);
      default: w_taken = 1'b0;
    endcase
  end

  assign br_decode   = pc_decode + w_imm_b;
  assign jal_decode  = pc_decode + w_imm_j;
  assign jalr_decode = (w_op1 + w_imm_i) & ~XLEN'(1);

  // Control transfers resolve in ID, so they also wait on an ALU result still in EX or MEM.
  always_comb begin
    w_hz_lu = r_idex.reg_we && r_idex.mem_re && (r_idex.rd != '0) &&
              ((w_use1 && r_idex.rd == w_rs1) || (w_use2 && r_idex.rd == w_rs2));
    w_hz_ctl = (w_br_ok || (w_jalr && w_legal)) && (
      (w_use1 && w_rs1 != '0 && ((r_idex.reg_we && r_idex.rd == w_rs1) ||
                                 (mem_reg_we && mem_rd == w_rs1))) ||
      (w_use2 && w_rs2 != '0 && ((r_idex.reg_we && r_idex.rd == w_rs2) ||
                                 (mem_reg_we && mem_rd == w_rs2))));
    w_hz = !rst && (w_hz_lu || w_hz_ctl);
  end

  always_comb begin
    pc_sel = 2'd0;
    if (!rst && !w_hz && w_legal) begin
      if (w_br_ok && w_taken) pc_sel = 2'd1;
      else if (w_jal)         pc_sel = 2'd2;
      else if (w_jalr)        pc_sel = 2'd3;
    end
    stall_if = w_hz;
    flush_if = (pc_sel != 2'd0);
  end

  always_comb begin
    w_nxt = '0;
    if (w_legal && !w_hz) begin
      w_nxt.pc     = pc_decode;
      w_nxt.rs1    = w_op1;
      w_nxt.rs2    = w_op2;
      w_nxt.imm    = w_imm;
      w_nxt.rd     = w_has_rd ? w_rd : '0;
      w_nxt.f3     = w_f3;
      w_nxt.f7b5   = instr_decode[30];
      w_nxt.opc    = w_opc;
      w_nxt.reg_we = w_has_rd && (w_rd != '0);
      w_nxt.mem_re = w_load;
      w_nxt.mem_we = w_store;
      w_nxt.vld    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_idex <= '0;
    else     r_idex <= w_nxt;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (rst) r_illegal <= 1'b0;
    else     r_illegal <= w_illegal;
  end
  assign illegal_ex = r_illegal;
`else
  logic w_illegal_unused;
  assign w_illegal_unused = w_illegal;
`endif

  assign pc_ex       = r_idex.pc;
  assign rs1_data_ex = r_idex.rs1;
  assign rs2_data_ex = r_idex.rs2;
  assign imm_ex      = r_idex.imm;
  assign rd_ex       = r_idex.rd;
  assign funct3_ex   = r_idex.f3;
  assign funct7b5_ex = r_idex.f7b5;
  assign opcode_ex   = r_idex.opc;
  assign reg_we_ex   = r_idex.reg_we;
  assign mem_re_ex   = r_idex.mem_re;
  assign mem_we_ex   = r_idex.mem_we;
  assign valid_ex    = r_idex.vld;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios plus randomized traffic against an instruction-level model.
module tb_decode;
  logic        clk, rst;
  logic [31:0] pc_decode, instr_decode;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_reg_we;
  logic [4:0]  mem_rd;
  logic [1:0]  pc_sel;
  logic [31:0] br_decode, jal_decode, jalr_decode;
  logic        stall_if, flush_if;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rd_ex;
  logic [2:0]  funct3_ex;
  logic        funct7b5_ex;
  logic [6:0]  opcode_ex;
  logic        reg_we_ex, mem_re_ex, mem_we_ex, valid_ex;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_ex;
`endif

  logic [31:0] regs [32];
  assign rs1_rdata = regs[instr_decode[19:15]];
  assign rs2_rdata = regs[instr_decode[24:20]];

  decode dut (
    .clk(clk), .rst(rst), .pc_decode(pc_decode), .instr_decode(instr_decode),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_reg_we(mem_reg_we), .mem_rd(mem_rd),
    .pc_sel(pc_sel), .br_decode(br_decode), .jal_decode(jal_decode), .jalr_decode(jalr_decode),
    .stall_if(stall_if), .flush_if(flush_if), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rd_ex(rd_ex), .funct3_ex(funct3_ex),
    .funct7b5_ex(funct7b5_ex), .opcode_ex(opcode_ex), .reg_we_ex(reg_we_ex),
    .mem_re_ex(mem_re_ex), .mem_we_ex(mem_we_ex),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_ex(illegal_ex),
`endif
    .valid_ex(valid_ex));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [6:0]  opc;
    logic        rwe, mre, mwe, vld, ill;
  } idex_t;

  idex_t       st, nxt;
  logic        st_ok;
  logic [1:0]  e_psel;
  logic        e_stall, e_flush;
  logic [31:0] e_br, e_jal, e_jalr;
  int          n_cmp, n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rv(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (wb_we && wb_rd == r) return wb_data;
    return regs[r];
  endfunction

  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && ((st.rwe && st.rd == r) || (mem_reg_we && mem_rd == r));
  endfunction

  // Instruction-level reference: what one ID slot must produce given the current EX/MEM state.
  task automatic model_eval();
    logic [31:0] ins, v1, v2, iI, iS, iB, iU, iJ, imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  a, b, rd;
    logic        legal, u1, u2, wr, taken, ctl, hz;
    ins = instr_decode;
    op = ins[6:0]; f3 = ins[14:12]; a = ins[19:15]; b = ins[24:20]; rd = ins[11:7];
    v1 = rv(a); v2 = rv(b);
    iI = {{20{ins[31]}}, ins[31:20]};
    iS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    iB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iU = {ins[31:12], 12'h0};
    iJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    legal = 1; u1 = 1; u2 = 0; wr = 0; imm = 0; taken = 0; ctl = 0;
    case (op)
      7'b0110111, 7'b0010111: begin u1 = 0; wr = 1; imm = iU; end
      7'b1101111: begin u1 = 0; wr = 1; imm = 4; end
      7'b1100111: begin wr = 1; imm = 4; ctl = 1; end
      7'b1100011: begin
        u2 = 1; imm = iB; ctl = 1;
        case (f3)
          3'd0: taken = (v1 == v2);
          3'd1: taken = (v1 != v2);
          3'd4: taken = ($signed(v1) <  $signed(v2));
          3'd5: taken = ($signed(v1) >= $signed(v2));
          3'd6: taken = (v1 <  v2);
          3'd7: taken = (v1 >= v2);
          default: legal = 0;
        endcase
      end
      7'b0000011, 7'b0010011: begin wr = 1; imm = iI; end
      7'b0100011: begin u2 = 1; imm = iS; end
      7'b0110011: begin u2 = 1; wr = 1; end
      default: legal = 0;
    endcase
    if (ins == 32'h0) legal = 0;
    if (!legal) begin u1 = 0; u2 = 0; ctl = 0; end
    hz = !rst && ((st.rwe && st.mre && st.rd != 0 && ((u1 && a == st.rd) || (u2 && b == st.rd))) ||
                  (ctl && ((u1 && busy(a)) || (u2 && busy(b)))));
    e_stall = hz;
    e_psel = 2'd0;
    if (!rst && !hz && legal) begin
      if (op == 7'b1100011 && taken) e_psel = 2'd1;
      else if (op == 7'b1101111)     e_psel = 2'd2;
      else if (op == 7'b1100111)     e_psel = 2'd3;
    end
    e_flush = (e_psel != 0);
    e_br = pc_decode + iB; e_jal = pc_decode + iJ; e_jalr = (v1 + iI) & ~32'd1;
    nxt = '0;
    if (!rst && legal && !hz) begin
      nxt.pc = pc_decode; nxt.r1 = v1; nxt.r2 = v2; nxt.imm = imm;
      nxt.rd = wr ? rd : 5'd0; nxt.f3 = f3; nxt.f7b5 = ins[30]; nxt.opc = op;
      nxt.rwe = wr && rd != 0; nxt.mre = (op == 7'b0000011); nxt.mwe = (op == 7'b0100011);
      nxt.vld = 1;
    end
    if (!rst && ins != 0 && !legal) nxt.ill = 1;
  endtask

  task automatic model_check();
    model_eval();
    chk("stall_if", 32'(stall_if), 32'(e_stall));
    chk("flush_if", 32'(flush_if), 32'(e_flush));
    chk("pc_sel", 32'(pc_sel), 32'(e_psel));
    if (!stall_if || !flush_if) n_cmp++; else begin n_bad++; $display("FAIL excl stall/flush both high"); end
    if (!rst) begin
      chk("rs1_addr", 32'(rs1_addr), 32'(instr_decode[19:15]));
      chk("rs2_addr", 32'(rs2_addr), 32'(instr_decode[24:20]));
      chk("br_decode", br_decode, e_br);
      chk("jal_decode", jal_decode, e_jal);
      chk("jalr_decode", jalr_decode, e_jalr);
    end
    if (st_ok) begin
      chk("pc_ex", pc_ex, st.pc);
      chk("rs1_data_ex", rs1_data_ex, st.r1);
      chk("rs2_data_ex", rs2_data_ex, st.r2);
      chk("imm_ex", imm_ex, st.imm);
      chk("rd_ex", 32'(rd_ex), 32'(st.rd));
      chk("funct3_ex", 32'(funct3_ex), 32'(st.f3));
      chk("funct7b5_ex", 32'(funct7b5_ex), 32'(st.f7b5));
      chk("opcode_ex", 32'(opcode_ex), 32'(st.opc));
      chk("ctl_ex", {28'h0, reg_we_ex, mem_re_ex, mem_we_ex, valid_ex},
          {28'h0, st.rwe, st.mre, st.mwe, st.vld});
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("illegal_ex", 32'(illegal_ex), 32'(st.ill));
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    st = nxt; st_ok = 1;
    #1;
  endtask

  task automatic put(input logic [31:0] ins);
    instr_decode = ins;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; st = '0; st_ok = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h5A5A_0001;
    rst = 1; wb_we = 0; wb_rd = 0; wb_data = 0; mem_reg_we = 0; mem_rd = 0;
    pc_decode = 32'h0; instr_decode = 32'h0050_0093;  // ADDI x1,x0,5

    tick(); tick();
    chk("rst_valid", 32'(valid_ex), 0);
    chk("rst_rd", 32'(rd_ex), 0);
    chk("rst_stall", 32'(stall_if), 0);
    chk("rst_flush", 32'(flush_if), 0);
    rst = 0; #1;
    tick();
    chk("addi_rd", 32'(rd_ex), 1);
    chk("addi_imm", imm_ex, 5);
    chk("addi_we", 32'(reg_we_ex), 1);
    chk("addi_valid", 32'(valid_ex), 1);

    put(32'h0001_2283); tick();                 // LW x5,0(x2)
    put(32'h0012_8333);                         // ADD x6,x5,x1
    chk("lu_stall", 32'(stall_if), 1);
    tick();
    chk("lu_bubble", 32'(valid_ex), 0);
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD; #1;
    chk("lu_release", 32'(stall_if), 0);
    tick();
    chk("lu_bypass", rs1_data_ex, 32'hDEAD);
    chk("lu_valid", 32'(valid_ex), 1);
    wb_we = 0;

    regs[1] = 7; regs[2] = 7; pc_decode = 32'h100;
    put(32'h0020_8863);                         // BEQ x1,x2,+16
    chk("beq_psel", 32'(pc_sel), 1);
    chk("beq_tgt", br_decode, 32'h110);
    chk("beq_flush", 32'(flush_if), 1);
    tick();
    regs[2] = 8; #1;
    chk("bne_psel", 32'(pc_sel), 0);
    chk("bne_flush", 32'(flush_if), 0);
    tick();

    regs[3] = 32'h203;
    put(32'h0011_80E7);                         // JALR x1,1(x3)
    chk("jalr_tgt", jalr_decode, 32'h204);
    chk("jalr_psel", 32'(pc_sel), 3);
    tick();
    put(32'h0070_0193); tick();                 // ADDI x3,x0,7
    put(32'h0011_80E7);
    chk("jalr_hz_stall", 32'(stall_if), 1);
    chk("jalr_hz_psel", 32'(pc_sel), 0);
    tick();
    chk("jalr_retry_psel", 32'(pc_sel), 3);
    tick();
    put(32'h0); tick();

    regs[1] = 32'hFFFF_FFFF; regs[2] = 1;
    put(32'h0020_C863); chk("blt_psel", 32'(pc_sel), 1); tick();
    put(32'h0020_E863); chk("bltu_psel", 32'(pc_sel), 0); tick();
    put(32'h0020_F863); chk("bgeu_psel", 32'(pc_sel), 1); tick();

    put(32'hFFFF_FFFF);
    chk("ill_psel", 32'(pc_sel), 0);
    chk("ill_stall", 32'(stall_if), 0);
    tick();
    chk("ill_valid", 32'(valid_ex), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", 32'(illegal_ex), 1);
`endif

    // Random traffic; the bench behaves like fetch: hold on stall, bubble after a redirect.
    for (int c = 0; c < 3000; c++) begin
      logic [6:0]  opcs [10];
      logic [31:0] ins;
      int          k;
      opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011};
      rst = ($urandom_range(0, 299) == 0);
      if (!e_stall || rst) begin
        if (e_flush) begin
          ins = 32'h0;
        end else begin
          k = $urandom_range(0, 11);
          ins = $urandom;
          if (k < 10) ins[6:0] = opcs[k];
          else if (k == 10) ins[6:0] = 7'($urandom);
          ins[19:15] = 5'($urandom_range(0, 7));
          ins[24:20] = 5'($urandom_range(0, 7));
          ins[11:7]  = 5'($urandom_range(0, 7));
          if (k == 11) ins = 32'h0;
        end
        instr_decode = ins;
        pc_decode = $urandom & 32'hFFFF_FFFC;
      end
      for (int r = 0; r < 8; r++)
        if ($urandom_range(0, 3) == 0)
          regs[r] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if ($urandom_range(0, 2) == 0) regs[1] = 32'hFFFF_FFFF;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      mem_reg_we = ($urandom_range(0, 2) == 0); mem_rd = 5'($urandom_range(0, 7));
      #1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
